// File: rtl/compute_core_pkg.sv
// Shared opcodes, FSM state type and width helper for the compute core.
package compute_core_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_READ = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_LOAD = 4'b1001;
  localparam logic [3:0] OP_ADD  = 4'b1010;
  localparam logic [3:0] OP_SUB  = 4'b1011;
  localparam logic [3:0] OP_AND  = 4'b1100;
  localparam logic [3:0] OP_OR   = 4'b1101;
  localparam logic [3:0] OP_NOT  = 4'b1110;
  localparam logic [3:0] OP_XOR  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MUL
  } state_t;

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/compute_core_p_if.sv
// Instruction-in / result-out bundle of the compute core.
interface compute_core_p_if
  import compute_core_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREG   = 16
);
  localparam int IDX_W   = $clog2(NREG);
  localparam int INSTR_W = 4 + IDX_W + max_w(DATA_W, 2 * IDX_W);

  logic               in_valid;
  logic [INSTR_W-1:0] in_instr;
  logic               in_ready;
  logic               res_valid;
  logic [DATA_W-1:0]  res_data;
  logic               res_zero;
  logic               res_carry;

  modport master (
    output in_valid, in_instr,
    input  in_ready, res_valid, res_data, res_zero, res_carry
  );

  modport slave (
    input  in_valid, in_instr,
    output in_ready, res_valid, res_data, res_zero, res_carry
  );

endinterface

// File: rtl/mul_seq.sv
// Shift-add multiplier: first partial product on start, one step per enabled cycle after.
module mul_seq #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   mplier;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (ena) begin
      if (start && !busy) begin
        busy   <= 1'b1;
        cnt    <= CNT_W'(DATA_W - 1);
        acc    <= b[0] ? {{DATA_W{1'b0}}, a} : '0;
        mcand  <= {{(DATA_W-1){1'b0}}, a, 1'b0};
        mplier <= b >> 1;
      end else if (busy) begin
        if (cnt != '0) begin
          acc    <= acc + (mplier[0] ? mcand : '0);
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
        end else begin
          busy <= 1'b0;
        end
      end
    end
  end

  // done is visible for the single cycle in which the core consumes the product
  assign done    = busy && (cnt == '0);
  assign product = acc;

endmodule

// File: rtl/compute_core_p.sv
// Register-file compute core: single-cycle ALU ops plus a multi-cycle multiply.
//   state   | meaning
//   IDLE    | no instruction pending
//   EXEC    | accepted single-cycle instruction executes on the next edge
//   MUL     | multiply in progress; result written when mul_seq reports done
module compute_core_p
  import compute_core_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREG   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  compute_core_p_if.slave bus
);
  localparam int IDX_W   = $clog2(NREG);
  localparam int LOW_W   = max_w(DATA_W, 2 * IDX_W);
  localparam int INSTR_W = 4 + IDX_W + LOW_W;

  state_t              state;
  logic [INSTR_W-1:0]  ir;
  logic [DATA_W-1:0]   regs [NREG];

  logic [3:0]          op;
  logic [IDX_W-1:0]    tgt;
  logic [IDX_W-1:0]    src0;
  logic [IDX_W-1:0]    src1;
  logic [DATA_W-1:0]   imm;
  logic [DATA_W-1:0]   opa;
  logic [DATA_W-1:0]   opb;
  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     diff;

  logic [DATA_W-1:0]   alu_res;
  logic                alu_carry;
  logic                alu_wr;

  logic                mul_start;
  logic                mul_busy;
  logic                mul_done;
  logic [2*DATA_W-1:0] mul_prod;

  logic                accept;
  logic                in_is_mul;

  assign op   = ir[INSTR_W-1 -: 4];
  assign tgt  = ir[INSTR_W-5 -: IDX_W];
  assign src0 = ir[LOW_W-1 -: IDX_W];
  assign src1 = ir[IDX_W-1:0];
  assign imm  = ir[DATA_W-1:0];
  assign opa  = regs[src0];
  assign opb  = regs[src1];
  assign sum  = {1'b0, opa} + {1'b0, opb};
  assign diff = {1'b0, opa} - {1'b0, opb};

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_wr    = 1'b0;
    case (op)
      OP_NOP:  alu_res = '0;
      OP_READ: alu_res = opa;
      OP_LOAD: begin alu_res = imm;       alu_wr = 1'b1; end
      OP_ADD:  begin {alu_carry, alu_res} = sum;  alu_wr = 1'b1; end
      OP_SUB:  begin {alu_carry, alu_res} = diff; alu_wr = 1'b1; end
      OP_AND:  begin alu_res = opa & opb; alu_wr = 1'b1; end
      OP_OR:   begin alu_res = opa | opb; alu_wr = 1'b1; end
      OP_NOT:  begin alu_res = ~opa;      alu_wr = 1'b1; end
      OP_XOR:  begin alu_res = opa ^ opb; alu_wr = 1'b1; end
      default: alu_res = '0;
    endcase
  end

  // Operands are sampled one edge after the MUL is accepted, so a write made on
  // the accepting edge is already visible to the multiplier.
  assign mul_start = (state == ST_MUL) && !mul_busy;

  mul_seq #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .start   (mul_start),
    .a       (opa),
    .b       (opb),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  assign bus.in_ready = ena && rst_n && ((state != ST_MUL) || mul_done);
  assign accept       = bus.in_valid && bus.in_ready;
  assign in_is_mul    = (bus.in_instr[INSTR_W-1 -: 4] == OP_MUL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      ir            <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_zero  <= 1'b0;
      bus.res_carry <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (ena) begin
      bus.res_valid <= 1'b0;
      case (state)
        ST_EXEC: begin
          if (alu_wr) regs[tgt] <= alu_res;
          bus.res_valid <= 1'b1;
          bus.res_data  <= alu_res;
          bus.res_zero  <= (alu_res == '0);
          bus.res_carry <= alu_carry;
        end
        ST_MUL: begin
          if (mul_done) begin
            regs[tgt]     <= mul_prod[DATA_W-1:0];
            bus.res_valid <= 1'b1;
            bus.res_data  <= mul_prod[DATA_W-1:0];
            bus.res_zero  <= (mul_prod[DATA_W-1:0] == '0);
            bus.res_carry <= |mul_prod[2*DATA_W-1:DATA_W];
          end
        end
        default: ;
      endcase
      if (accept) begin
        ir    <= bus.in_instr;
        state <= in_is_mul ? ST_MUL : ST_EXEC;
      end else if ((state == ST_EXEC) || ((state == ST_MUL) && mul_done)) begin
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_compute_core_p.sv
// Randomized bench for compute_core_p against an arithmetic register-file model.
module tb_compute_core_p;

  logic clk = 1'b0;
  logic rst_a, rst_b, ena_a, ena_b;
  int   n_cmp = 0;
  int   n_err = 0;
  int   mr [16];

  compute_core_p_if #(.DATA_W(8),  .NREG(16)) bus_a ();
  compute_core_p_if #(.DATA_W(16), .NREG(8))  bus_b ();

  compute_core_p #(.DATA_W(8), .NREG(16)) dut_a (
    .clk(clk), .rst_n(rst_a), .ena(ena_a), .bus(bus_a)
  );
  compute_core_p #(.DATA_W(16), .NREG(8)) dut_b (
    .clk(clk), .rst_n(rst_b), .ena(ena_b), .bus(bus_b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference semantics for the 8-bit / 16-register instance.
  function automatic void model_a(input logic [15:0] ins, output int d, output int c, output int lat);
    int op  = int'(ins[15:12]);
    int tgt = int'(ins[11:8]);
    int a   = mr[int'(ins[7:4])];
    int b   = mr[int'(ins[3:0])];
    int imm = int'(ins[7:0]);
    bit wr  = 1'b1;
    d = 0; c = 0; lat = 1;
    case (op)
      1:  begin d = a; wr = 1'b0; end
      8:  begin d = (a * b) % 256; c = ((a * b) > 255); lat = 9; end
      9:  d = imm;
      10: begin d = (a + b) % 256; c = ((a + b) > 255); end
      11: begin d = (a - b + 256) % 256; c = (a < b); end
      12: d = a & b;
      13: d = a | b;
      14: d = 255 - a;
      15: d = a ^ b;
      default: begin d = 0; wr = 1'b0; end
    endcase
    if (wr) mr[tgt] = d;
  endfunction

  task automatic exec_a(input logic [15:0] ins, input int stall_at,
                        output logic [7:0] d, output logic z, output logic c,
                        output int lat, output int rdy_lo);
    lat = -1; rdy_lo = 0; d = '0; z = 1'b0; c = 1'b0;
    @(negedge clk);
    ena_a = 1'b1;
    bus_a.in_valid = 1'b1;
    bus_a.in_instr = ins;
    #1 check_eq("accept_ready", 64'(bus_a.in_ready), 64'd1);
    @(posedge clk);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc > 1 && bus_a.res_valid) begin
        lat = cyc - 1;
        d = bus_a.res_data; z = bus_a.res_zero; c = bus_a.res_carry;
        break;
      end
      ena_a = !(stall_at > 0 && cyc >= stall_at && cyc < stall_at + 3);
      #1;
      // junk offered while the core is not ready must not be taken
      if (bus_a.in_ready) bus_a.in_valid = 1'b0;
      else begin
        bus_a.in_valid = 1'b1;
        bus_a.in_instr = 16'($urandom);
      end
      if (ena_a && !bus_a.in_ready) rdy_lo++;
      @(posedge clk);
    end
    bus_a.in_valid = 1'b0;
    ena_a = 1'b1;
    if (lat < 0) check_eq("a_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_a(input string tag, input logic [15:0] ins, input int stall_at,
                       output logic [7:0] d, output logic c);
    int ed, ec, el, lat, rl;
    logic z;
    model_a(ins, ed, ec, el);
    if (stall_at > 0) el += 3;
    exec_a(ins, stall_at, d, z, c, lat, rl);
    check_eq({tag, ".data"},  64'(d),   64'(ed));
    check_eq({tag, ".zero"},  64'(z),   64'(ed == 0));
    check_eq({tag, ".carry"}, 64'(c),   64'(ec));
    check_eq({tag, ".lat"},   64'(lat), 64'(el));
    check_eq({tag, ".rdy_lo"}, 64'(rl), 64'((ins[15:12] == 4'h8) ? 8 : 0));
  endtask

  task automatic exec_b(input logic [22:0] ins, output logic [15:0] d, output logic z,
                        output logic c, output int lat);
    lat = -1; d = '0; z = 1'b0; c = 1'b0;
    @(negedge clk);
    bus_b.in_valid = 1'b1;
    bus_b.in_instr = ins;
    @(posedge clk);
    @(negedge clk);
    bus_b.in_valid = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus_b.res_valid) begin
        lat = cyc;
        d = bus_b.res_data; z = bus_b.res_zero; c = bus_b.res_carry;
        break;
      end
    end
    if (lat < 0) check_eq("b_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  d8;
    logic [15:0] d16;
    logic        c, z;
    int          lat, stray, ed, ec, el;
    int          e0, e1, e2;

    rst_a = 1'b0; rst_b = 1'b0; ena_a = 1'b1; ena_b = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_instr = '0;
    bus_b.in_valid = 1'b0; bus_b.in_instr = '0;
    repeat (2) @(negedge clk);
    check_eq("rst.in_ready", 64'(bus_a.in_ready), 64'd0);
    check_eq("rst.res_valid", 64'(bus_a.res_valid), 64'd0);
    check_eq("rst.res_data",  64'(bus_a.res_data),  64'd0);
    check_eq("rst.res_zero",  64'(bus_a.res_zero),  64'd0);
    check_eq("rst.res_carry", 64'(bus_a.res_carry), 64'd0);
    rst_a = 1'b1; rst_b = 1'b1;
    #1 check_eq("post_rst.in_ready", 64'(bus_a.in_ready), 64'd1);

    run_a("ld_r1", 16'h9105, 0, d8, c);
    run_a("ld_r2", 16'h92FB, 0, d8, c);
    run_a("add_wrap", 16'hA312, 0, d8, c);
    check_eq("add_wrap.const", 64'({c, d8}), 64'h100);

    run_a("ld_r1b", 16'h9103, 0, d8, c);
    run_a("ld_r2b", 16'h9205, 0, d8, c);
    run_a("sub_borrow", 16'hB412, 0, d8, c);
    check_eq("sub_borrow.const", 64'({c, d8}), 64'h1FE);

    run_a("ld_r1c", 16'h9112, 0, d8, c);
    run_a("ld_r2c", 16'h9210, 0, d8, c);
    run_a("mul", 16'h8512, 0, d8, c);
    check_eq("mul.const", 64'({c, d8}), 64'h120);
    run_a("read_r5", 16'h1050, 0, d8, c);
    check_eq("read_r5.const", 64'(d8), 64'h20);

    run_a("ld_r6", 16'h960D, 0, d8, c);
    run_a("mul_stall", 16'h8716, 3, d8, c);
    run_a("ld_r8", 16'h9890, 0, d8, c);
    run_a("self_add", 16'hA888, 0, d8, c);
    run_a("nop", 16'h0000, 0, d8, c);

    // back-to-back dependent stream with in_valid held high
    model_a(16'h9107, e0, ec, el);
    model_a(16'hA111, e1, ec, el);
    model_a(16'hA111, e2, ec, el);
    @(negedge clk); bus_a.in_valid = 1'b1; bus_a.in_instr = 16'h9107;
    @(negedge clk); bus_a.in_instr = 16'hA111;
    @(negedge clk);
    check_eq("b2b0.valid", 64'(bus_a.res_valid), 64'd1);
    check_eq("b2b0.data",  64'(bus_a.res_data),  64'(e0));
    @(negedge clk); bus_a.in_valid = 1'b0;
    check_eq("b2b1.valid", 64'(bus_a.res_valid), 64'd1);
    check_eq("b2b1.data",  64'(bus_a.res_data),  64'(e1));
    @(negedge clk);
    check_eq("b2b2.valid", 64'(bus_a.res_valid), 64'd1);
    check_eq("b2b2.data",  64'(bus_a.res_data),  64'(e2));
    @(negedge clk);
    check_eq("b2b_end.valid", 64'(bus_a.res_valid), 64'd0);

    // reset in the third cycle of a multiply
    run_a("ld_r15", 16'h9FAA, 0, d8, c);
    @(negedge clk); bus_a.in_valid = 1'b1; bus_a.in_instr = 16'h8512;
    @(negedge clk); bus_a.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_a = 1'b0;
    #1 check_eq("mulrst.in_ready", 64'(bus_a.in_ready), 64'd0);
    @(negedge clk); rst_a = 1'b1;
    check_eq("mulrst.res_valid", 64'(bus_a.res_valid), 64'd0);
    check_eq("mulrst.res_data",  64'(bus_a.res_data),  64'd0);
    check_eq("mulrst.res_carry", 64'(bus_a.res_carry), 64'd0);
    stray = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus_a.res_valid) stray++;
    end
    check_eq("mulrst.stray", 64'(stray), 64'd0);
    check_eq("mulrst.in_ready", 64'(bus_a.in_ready), 64'd1);
    for (int i = 0; i < 16; i++) mr[i] = 0;
    run_a("read_r15", 16'h10F0, 0, d8, c);
    check_eq("read_r15.const", 64'(d8), 64'd0);
    run_a("read_r5_rst", 16'h1050, 0, d8, c);

    for (int n = 0; n < 150; n++) begin
      logic [15:0] ins;
      int st;
      ins = 16'($urandom);
      st  = (ins[15:12] == 4'h8 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
      run_a("rand", ins, st, d8, c);
    end

    // 16-bit / 8-register instance
    exec_b({4'h9, 3'd2, 16'hFFFF}, d16, z, c, lat);
    check_eq("b_load.data", 64'(d16), 64'hFFFF);
    exec_b({4'hE, 3'd3, 3'd2, 13'd0}, d16, z, c, lat);
    check_eq("b_not.data", 64'(d16), 64'h0000);
    check_eq("b_not.zero", 64'(z), 64'd1);
    check_eq("b_not.lat",  64'(lat), 64'd1);
    exec_b({4'h9, 3'd5, 16'h0100}, d16, z, c, lat);
    exec_b({4'h9, 3'd6, 16'h1234}, d16, z, c, lat);
    exec_b({4'h8, 3'd4, 3'd6, 10'd0, 3'd5}, d16, z, c, lat);
    check_eq("b_mul.data",  64'(d16), 64'h3400);
    check_eq("b_mul.carry", 64'(c),   64'd1);
    check_eq("b_mul.lat",   64'(lat), 64'd17);
    exec_b({4'h1, 3'd0, 3'd4, 13'd0}, d16, z, c, lat);
    check_eq("b_read.data", 64'(d16), 64'h3400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
